// File: rtl/control_unit_pkg.sv
// Shared decode constants and the registered control bundle for control_unit.
// Illegal-instruction detection is enabled by defining CU_ILLEGAL_DETECT_EN.
package control_unit_pkg;

  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [6:0] Funct7Base = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;
  localparam logic [2:0] Funct3Sr   = 3'b101;

  localparam logic [2:0] ImmI    = 3'b000;
  localparam logic [2:0] ImmS    = 3'b001;
  localparam logic [2:0] ImmB    = 3'b010;
  localparam logic [2:0] ImmU    = 3'b011;
  localparam logic [2:0] ImmJ    = 3'b100;
  localparam logic [2:0] ImmNone = 3'b111;

  localparam logic [2:0] DmWord = 3'b010;

  typedef struct packed {
    logic       type_alu;
    logic [2:0] type_dm;
    logic       salida_funct3;
    logic       store;
    logic       control_alu;
    logic       control_rf;
    logic       we;
    logic [2:0] funct_imm;
  } ctrl_t;

  // A bubble has every control zero, but still advertises "no immediate".
  function automatic ctrl_t bubble_ctrl();
    ctrl_t c;
    c           = '0;
    c.funct_imm = ImmNone;
    return c;
  endfunction

endpackage

// File: rtl/control_unit_dec.sv
// Purely combinational instruction decoder feeding the control_unit output register.
// CU_ILLEGAL_DETECT_EN adds funct-field validation and an illegal flag.
module control_unit_dec
  import control_unit_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o
`ifdef CU_ILLEGAL_DETECT_EN
  ,
  output logic       illegal_o
`endif
);

  ctrl_t dec;
  logic  unknown;
  logic  bubble;

  always_comb begin
    dec           = '0;
    dec.type_dm   = DmWord;
    dec.funct_imm = ImmNone;
    unknown       = 1'b0;
    case (opcode_i)
      OpRtype: begin
        dec.salida_funct3 = 1'b1;
        dec.we            = 1'b1;
        dec.control_alu   = (funct7_i == Funct7Alt);
      end
      OpImm: begin
        dec.type_alu      = 1'b1;
        dec.salida_funct3 = 1'b1;
        dec.we            = 1'b1;
        dec.funct_imm     = ImmI;
        dec.control_alu   = (funct3_i == Funct3Sr) && (funct7_i == Funct7Alt);
      end
      OpLoad: begin
        dec.type_alu   = 1'b1;
        dec.we         = 1'b1;
        dec.control_rf = 1'b1;
        dec.funct_imm  = ImmI;
        dec.type_dm    = funct3_i;
      end
      OpStore: begin
        dec.type_alu  = 1'b1;
        dec.store     = 1'b1;
        dec.funct_imm = ImmS;
        dec.type_dm   = funct3_i;
      end
      OpBranch: begin
        dec.salida_funct3 = 1'b1;
        dec.funct_imm     = ImmB;
      end
      OpLui, OpAuipc: begin
        dec.type_alu  = 1'b1;
        dec.we        = 1'b1;
        dec.funct_imm = ImmU;
      end
      OpJal: begin
        dec.we        = 1'b1;
        dec.funct_imm = ImmJ;
      end
      OpJalr: begin
        dec.type_alu  = 1'b1;
        dec.we        = 1'b1;
        dec.funct_imm = ImmI;
      end
      default: unknown = 1'b1;
    endcase
  end

`ifdef CU_ILLEGAL_DETECT_EN
  logic field_bad;

  always_comb begin
    field_bad = 1'b0;
    case (opcode_i)
      OpRtype:  field_bad = !(funct7_i inside {Funct7Base, Funct7Alt});
      OpLoad:   field_bad = funct3_i inside {3'b011, 3'b110, 3'b111};
      OpStore:  field_bad = funct3_i > 3'b010;
      OpBranch: field_bad = funct3_i inside {3'b010, 3'b011};
      default:  field_bad = 1'b0;
    endcase
  end

  assign bubble    = unknown | field_bad;
  assign illegal_o = bubble;
`else
  assign bubble = unknown;
`endif

  assign ctrl_o = bubble ? bubble_ctrl() : dec;

endmodule

// File: rtl/control_unit.sv
// Instruction control unit: combinational decode followed by one output register stage.
// Define CU_ILLEGAL_DETECT_EN to add the registered illegal output.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       Type_alu,
  output logic [2:0] Type_dm,
  output logic       salida_funct3,
  output logic       store,
  output logic       controlALU,
  output logic       controlRF,
  output logic       we,
  output logic [2:0] funct_imm
`ifdef CU_ILLEGAL_DETECT_EN
  ,
  output logic       illegal
`endif
);

  ctrl_t ctrl_d, ctrl_q;

`ifdef CU_ILLEGAL_DETECT_EN
  logic illegal_d, illegal_q;

  control_unit_dec u_dec (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .ctrl_o    (ctrl_d),
    .illegal_o (illegal_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  control_unit_dec u_dec (
    .opcode_i (opcode),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .ctrl_o   (ctrl_d)
  );
`endif

  // Reset clears everything, including funct_imm and Type_dm, unlike a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign Type_alu      = ctrl_q.type_alu;
  assign Type_dm       = ctrl_q.type_dm;
  assign salida_funct3 = ctrl_q.salida_funct3;
  assign store         = ctrl_q.store;
  assign controlALU    = ctrl_q.control_alu;
  assign controlRF     = ctrl_q.control_rf;
  assign we            = ctrl_q.we;
  assign funct_imm     = ctrl_q.funct_imm;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; observed word packs
// {Type_alu, Type_dm, salida_funct3, store, controlALU, controlRF, we, funct_imm}.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Type_alu, salida_funct3, store, controlALU, controlRF, we;
  logic [2:0] Type_dm, funct_imm;
`ifdef CU_ILLEGAL_DETECT_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;

  logic [11:0] obs;
  assign obs = {Type_alu, Type_dm, salida_funct3, store, controlALU, controlRF, we, funct_imm};

  // Hand-computed expected words, field order as in the header.
  localparam logic [11:0] ExpZero   = 12'b0_000_0_0_0_0_0_000;
  localparam logic [11:0] ExpAdd    = 12'b0_010_1_0_0_0_1_111;
  localparam logic [11:0] ExpSub    = 12'b0_010_1_0_1_0_1_111;
  localparam logic [11:0] ExpSrai   = 12'b1_010_1_0_1_0_1_000;
  localparam logic [11:0] ExpAddi   = 12'b1_010_1_0_0_0_1_000;
  localparam logic [11:0] ExpLbu    = 12'b1_100_0_0_0_1_1_000;
  localparam logic [11:0] ExpSw     = 12'b1_010_0_1_0_0_0_001;
  localparam logic [11:0] ExpBne    = 12'b0_010_1_0_0_0_0_010;
  localparam logic [11:0] ExpUpper  = 12'b1_010_0_0_0_0_1_011;
  localparam logic [11:0] ExpJal    = 12'b0_010_0_0_0_0_1_100;
  localparam logic [11:0] ExpJalr   = 12'b1_010_0_0_0_0_1_000;
  localparam logic [11:0] ExpBubble = 12'b0_000_0_0_0_0_0_111;

  always #5 clk = ~clk;

  control_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .Type_alu      (Type_alu),
    .Type_dm       (Type_dm),
    .salida_funct3 (salida_funct3),
    .store         (store),
    .controlALU    (controlALU),
    .controlRF     (controlRF),
    .we            (we),
    .funct_imm     (funct_imm)
`ifdef CU_ILLEGAL_DETECT_EN
    ,
    .illegal       (illegal)
`endif
  );

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 7'b0110011;
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    step();
    checks++;
    if (obs !== ExpZero) begin
      errors++;
      $display("FAIL reset_state obs=%b exp=%b", obs, ExpZero);
    end
`ifdef CU_ILLEGAL_DETECT_EN
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal obs=%b exp=0", illegal);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    drive(7'b0110011, 3'b000, 7'b0000000);
    step();
    checks++;
    if (obs !== ExpAdd) begin
      errors++;
      $display("FAIL rtype_add obs=%b exp=%b", obs, ExpAdd);
    end
    drive(7'b0110011, 3'b101, 7'b0100000);
    step();
    checks++;
    if (obs !== ExpSub) begin
      errors++;
      $display("FAIL rtype_sra obs=%b exp=%b", obs, ExpSub);
    end
  endtask

  task automatic test_imm_alu();
    drive(7'b0010011, 3'b101, 7'b0100000);
    step();
    checks++;
    if (obs !== ExpSrai) begin
      errors++;
      $display("FAIL imm_srai obs=%b exp=%b", obs, ExpSrai);
    end
    // funct7 pattern alone must not select the alternate op without funct3 = 101
    drive(7'b0010011, 3'b000, 7'b0100000);
    step();
    checks++;
    if (obs !== ExpAddi) begin
      errors++;
      $display("FAIL imm_addi obs=%b exp=%b", obs, ExpAddi);
    end
  endtask

  task automatic test_mem();
    drive(7'b0000011, 3'b100, 7'b0000000);
    step();
    checks++;
    if (obs !== ExpLbu) begin
      errors++;
      $display("FAIL load_lbu obs=%b exp=%b", obs, ExpLbu);
    end
    drive(7'b0100011, 3'b010, 7'b0000000);
    step();
    checks++;
    if (obs !== ExpSw) begin
      errors++;
      $display("FAIL store_sw obs=%b exp=%b", obs, ExpSw);
    end
  endtask

  task automatic test_control_flow();
    drive(7'b1100011, 3'b001, 7'b0000000);
    step();
    checks++;
    if (obs !== ExpBne) begin
      errors++;
      $display("FAIL branch_bne obs=%b exp=%b", obs, ExpBne);
    end
    drive(7'b0110111, 3'b000, 7'b0000000);
    step();
    checks++;
    if (obs !== ExpUpper) begin
      errors++;
      $display("FAIL lui obs=%b exp=%b", obs, ExpUpper);
    end
    drive(7'b0010111, 3'b000, 7'b0000000);
    step();
    checks++;
    if (obs !== ExpUpper) begin
      errors++;
      $display("FAIL auipc obs=%b exp=%b", obs, ExpUpper);
    end
    drive(7'b1101111, 3'b000, 7'b0000000);
    step();
    checks++;
    if (obs !== ExpJal) begin
      errors++;
      $display("FAIL jal obs=%b exp=%b", obs, ExpJal);
    end
    drive(7'b1100111, 3'b000, 7'b0000000);
    step();
    checks++;
    if (obs !== ExpJalr) begin
      errors++;
      $display("FAIL jalr obs=%b exp=%b", obs, ExpJalr);
    end
  endtask

  task automatic test_bubble();
    drive(7'b1111111, 3'b000, 7'b0000000);
    step();
    checks++;
    if (obs !== ExpBubble) begin
      errors++;
      $display("FAIL bubble obs=%b exp=%b", obs, ExpBubble);
    end
`ifdef CU_ILLEGAL_DETECT_EN
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL bubble_illegal obs=%b exp=1", illegal);
    end
`endif
  endtask

  task automatic test_latency();
    drive(7'b0000011, 3'b100, 7'b0000000);
    step();
    drive(7'b0100011, 3'b010, 7'b0000000);
    #1;
    checks++;
    if (obs !== ExpLbu) begin
      errors++;
      $display("FAIL latency_hold obs=%b exp=%b", obs, ExpLbu);
    end
    step();
    checks++;
    if (obs !== ExpSw) begin
      errors++;
      $display("FAIL latency_update obs=%b exp=%b", obs, ExpSw);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [4] = '{7'b0110011, 7'b1100011, 7'b1111111, 7'b1101111};
    logic [2:0]  f3s [4] = '{3'b101, 3'b001, 3'b000, 3'b000};
    logic [6:0]  f7s [4] = '{7'b0100000, 7'b0000000, 7'b0000000, 7'b0000000};
    logic [11:0] exps[4] = '{ExpSub, ExpBne, ExpBubble, ExpJal};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], f3s[i], f7s[i]);
      step();
      checks++;
      if (obs !== exps[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d] obs=%b exp=%b", i, obs, exps[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(7'b0000011, 3'b100, 7'b0000000);
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== ExpZero) begin
      errors++;
      $display("FAIL async_clear obs=%b exp=%b", obs, ExpZero);
    end
    step();
    checks++;
    if (obs !== ExpZero) begin
      errors++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, ExpZero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== ExpZero) begin
      errors++;
      $display("FAIL release_no_edge obs=%b exp=%b", obs, ExpZero);
    end
    step();
    checks++;
    if (obs !== ExpLbu) begin
      errors++;
      $display("FAIL first_edge_after_reset obs=%b exp=%b", obs, ExpLbu);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm_alu();
    test_mem();
    test_control_flow();
    test_bubble();
    test_latency();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Port order SHALL be: clk, rst_n, opcode, funct3, funct7, Type_alu, Type_dm, salida_funct3, store, controlALU, controlRF, we, funct_imm.
REQ-002 clk  input  1  single clock; all outputs SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  7  instruction bits [6:0].
REQ-005 funct3  input  3  instruction bits [14:12].
REQ-006 funct7  input  7  instruction bits [31:25].
REQ-007 Type_alu  output  1  ALU operand-B select: 0 = rs2, 1 = immediate.
REQ-008 Type_dm  output  3  data-memory access size/sign code.
REQ-009 salida_funct3  output  1  1 = ALU op taken from funct3; 0 = ALU forced to ADD.
REQ-010 store  output  1  data-memory write enable.
REQ-011 controlALU  output  1  alternate ALU op (SUB/SRA/SRAI).
REQ-012 controlRF  output  1  write-back source: 0 = ALU, 1 = data memory.
REQ-013 we  output  1  register-file write enable.
REQ-014 funct_imm  output  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J, 111 none.

Function
REQ-015 Decode SHALL be combinational from opcode/funct3/funct7; all outputs SHALL be registered, latency exactly one clk edge, new decode every cycle, no handshake.
REQ-016 R-type 0110011: Type_alu 0, salida_funct3 1, we 1, controlRF 0, store 0, funct_imm 111, controlALU = (funct7 == 0100000).
REQ-017 I-ALU 0010011: Type_alu 1, salida_funct3 1, we 1, controlRF 0, funct_imm 000; controlALU 1 only when funct3 = 101 and funct7 = 0100000.
REQ-018 Load 0000011: Type_alu 1, salida_funct3 0, we 1, controlRF 1, funct_imm 000, Type_dm = funct3.
REQ-019 Store 0100011: Type_alu 1, salida_funct3 0, store 1, we 0, funct_imm 001, Type_dm = funct3.
REQ-020 Branch 1100011: Type_alu 0, salida_funct3 1, we 0, funct_imm 010.
REQ-021 LUI 0110111 / AUIPC 0010111: Type_alu 1, salida_funct3 0, we 1, funct_imm 011.
REQ-022 JAL 1101111: we 1, funct_imm 100; JALR 1100111: Type_alu 1, we 1, funct_imm 000; salida_funct3 0 for both.
REQ-023 Type_dm SHALL be 010 for every non-load/store opcode; unlisted outputs per opcode SHALL be 0.
REQ-024 Any other opcode SHALL produce a bubble: all outputs 0 except funct_imm 111.

Reset
REQ-025 rst_n low SHALL immediately clear all outputs to 0 (funct_imm 000, Type_dm 000), independent of clk.
REQ-026 First rising edge after rst_n deasserts SHALL register the current decode; reset asserted mid-stream SHALL discard the in-flight decode.

Configuration
REQ-027 Macro CU_ILLEGAL_DETECT_EN, when defined, SHALL add output illegal (1 bit, registered, reset 0), placed last in the port list.
REQ-028 With CU_ILLEGAL_DETECT_EN: illegal = 1 and bubble outputs for unknown opcode, R-type funct7 not in {0000000, 0100000}, load funct3 in {011, 110, 111}, store funct3 > 010, or branch funct3 in {010, 011}.
REQ-029 Without CU_ILLEGAL_DETECT_EN: no illegal port; only unknown opcodes bubble; funct fields are not validated.

Structure
REQ-030 A shared package SHALL hold opcode constants, funct_imm format codes, and Type_dm codes.
REQ-031 One sub-module, control_unit_dec (pure combinational decoder), SHALL feed the output register stage in control_unit.

Verification
REQ-032 opcode 0110011, funct3 000, funct7 0000000, one clk -> Type_alu 0, salida_funct3 1, controlALU 0, we 1, store 0, controlRF 0, funct_imm 111, Type_dm 010.
REQ-033 opcode 0110011, funct3 101, funct7 0100000 -> controlALU 1, we 1.
REQ-034 opcode 0000011, funct3 100 -> Type_dm 100, controlRF 1, Type_alu 1, we 1, funct_imm 000.
REQ-035 opcode 0100011, funct3 010 -> store 1, we 0, funct_imm 001, Type_dm 010.
REQ-036 opcode 1111111 -> bubble (we 0, store 0, funct_imm 111); illegal 1 when CU_ILLEGAL_DETECT_EN is defined.
REQ-037 rst_n pulled low between clk edges -> all outputs 0 before the next edge.
